// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters between decode and writeback.
// Decode is stalled while a source is owed a write, or while the destination's counter
// is saturated. Issue increments a counter; writeback and squash decrement it.
module reg_scoreboard #(
  parameter int NREGS    = 32,
  parameter int CNT_W    = 2,
  parameter int MAX_PEND = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wen,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             kill_valid,
  input  logic [4:0]       kill_rd,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREGS-1:0] busy_vec,
  output logic             sb_err
);

  // One spare bit so that increment-then-decrement arithmetic cannot wrap.
  localparam int CW1 = CNT_W + 1;

  logic [CNT_W-1:0] pending_reg  [NREGS];
  logic [CNT_W-1:0] pending_next [NREGS];
  logic [NREGS-1:0] underflow;
  logic             sb_err_reg;
  logic             src_hz;
  logic             sat_hz;

  // Hazard detection on current-cycle counters only; writeback is not bypassed.
  always_comb begin
    src_hz = 1'b0;
    sat_hz = 1'b0;
    if (id_valid) begin
      if (id_use_rs1 && id_rs1 != 5'd0 && pending_reg[id_rs1] != '0) src_hz = 1'b1;
      if (id_use_rs2 && id_rs2 != 5'd0 && pending_reg[id_rs2] != '0) src_hz = 1'b1;
      if (id_rd_wen && id_rd != 5'd0 && pending_reg[id_rd] == CNT_W'(MAX_PEND)) sat_hz = 1'b1;
    end
  end

  assign stall      = src_hz || sat_hz;
  assign issue_fire = id_valid && !stall;
  assign sb_err     = sb_err_reg;

  // Per-register next-count: net of one increment and up to two decrements, clamped at zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is hard-wired ready: never counted, never busy, never underflows.
        assign pending_next[gi] = '0;
        assign underflow[gi]    = 1'b0;
        assign busy_vec[gi]     = 1'b0;
      end else begin : g_cnt
        logic           inc;
        logic           dec_w;
        logic           dec_k;
        logic [CW1-1:0] up;
        logic [CW1-1:0] dec;
        assign inc   = issue_fire && id_rd_wen && (id_rd == 5'(gi));
        assign dec_w = wb_valid && (wb_rd == 5'(gi));
        assign dec_k = kill_valid && (kill_rd == 5'(gi));
        assign up    = {1'b0, pending_reg[gi]} + CW1'(inc);
        assign dec   = CW1'(dec_w) + CW1'(dec_k);
        assign underflow[gi]    = dec > up;
        assign pending_next[gi] = underflow[gi] ? '0 : CNT_W'(up - dec);
        assign busy_vec[gi]     = pending_reg[gi] != '0;
      end
    end
  endgenerate

  // Counter and sticky-error state; reset overrides any same-cycle issue/wb/kill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) pending_reg[i] <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) pending_reg[i] <= pending_next[i];
      sb_err_reg <= sb_err_reg | (|underflow);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver applies one vector per cycle and queues the
// hand-computed response; a monitor pops and compares on the falling edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd, kill_rd;
  logic        id_use_rs1, id_use_rs2, id_rd_wen, wb_valid, kill_valid;
  logic        stall, issue_fire, sb_err;
  logic [31:0] busy_vec;

  typedef struct {
    string       nm;
    logic        stall;
    logic        fire;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREGS(32), .CNT_W(2), .MAX_PEND(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_rd_wen  (id_rd_wen),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .kill_valid (kill_valid),
    .kill_rd    (kill_rd),
    .stall      (stall),
    .issue_fire (issue_fire),
    .busy_vec   (busy_vec),
    .sb_err     (sb_err)
  );

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, field, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle, while inputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %-10s stall=%0b fire=%0b busy=%h err=%0b", e.nm, stall, issue_fire, busy_vec, sb_err);
        chk(e.nm, "stall",      {31'd0, stall},      {31'd0, e.stall});
        chk(e.nm, "issue_fire", {31'd0, issue_fire}, {31'd0, e.fire});
        chk(e.nm, "busy_vec",   busy_vec,            e.busy);
        chk(e.nm, "sb_err",     {31'd0, sb_err},     {31'd0, e.err});
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the expected response.
  task automatic step(input string nm, input logic rn,
                      input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wen,
                      input logic wv, input logic [4:0] wr,
                      input logic kv, input logic [4:0] kr,
                      input logic e_stall, input logic e_fire,
                      input logic [31:0] e_busy, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; id_valid = v;
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_rd_wen = wen;
    wb_valid = wv; wb_rd = wr; kill_valid = kv; kill_rd = kr;
    e.nm = nm; e.stall = e_stall; e.fire = e_fire; e.busy = e_busy; e.err = e_err;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_rd_wen = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    kill_valid = 1'b0; kill_rd = '0;
    repeat (2) @(posedge clk);

    //    name        rn v  rs1 u1 rs2 u2 rd  wen wv wr  kv kr   stall fire busy       err
    step("reset",     1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0,   0, 0, 32'h0,      0);
    step("iss5",      1, 1, 0,  0, 0,  0, 5,  1,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("raw5",      1, 1, 5,  1, 0,  0, 0,  0,  0, 0,  0, 0,   1, 0, 32'h20,     0);
    step("raw5_wb",   1, 1, 5,  1, 0,  0, 0,  0,  1, 5,  0, 0,   1, 0, 32'h20,     0);
    step("raw5_clr",  1, 1, 5,  1, 0,  0, 0,  0,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("iss0",      1, 1, 0,  0, 0,  0, 0,  1,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("rd0",       1, 1, 0,  1, 0,  1, 0,  0,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("iss7a",     1, 1, 0,  0, 0,  0, 7,  1,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("iss7b",     1, 1, 0,  0, 0,  0, 7,  1,  0, 0,  0, 0,   0, 1, 32'h80,     0);
    step("iss7c",     1, 1, 0,  0, 0,  0, 7,  1,  0, 0,  0, 0,   0, 1, 32'h80,     0);
    step("sat7",      1, 1, 0,  0, 0,  0, 7,  1,  0, 0,  0, 0,   1, 0, 32'h80,     0);
    step("raw7_rs2",  1, 1, 0,  0, 7,  1, 0,  0,  0, 0,  0, 0,   1, 0, 32'h80,     0);
    step("novalid",   1, 0, 7,  1, 0,  0, 7,  1,  1, 0,  1, 0,   0, 0, 32'h80,     0);
    step("wbkill7",   1, 0, 0,  0, 0,  0, 0,  0,  1, 7,  1, 7,   0, 0, 32'h80,     0);
    step("wb7",       1, 0, 0,  0, 0,  0, 0,  0,  1, 7,  0, 0,   0, 0, 32'h80,     0);
    step("iss9",      1, 1, 0,  0, 0,  0, 9,  1,  0, 0,  0, 0,   0, 1, 32'h0,      0);
    step("iss9_wb9",  1, 1, 0,  0, 0,  0, 9,  1,  1, 9,  0, 0,   0, 1, 32'h200,    0);
    step("chk9",      1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0,   0, 0, 32'h200,    0);
    step("kill4",     1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  1, 4,   0, 0, 32'h200,    0);
    step("err_set",   1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0,   0, 0, 32'h200,    1);
    step("err_hold",  1, 0, 0,  0, 0,  0, 0,  0,  1, 9,  0, 0,   0, 0, 32'h200,    1);
    step("iss3a",     1, 1, 0,  0, 0,  0, 3,  1,  0, 0,  0, 0,   0, 1, 32'h0,      1);
    step("iss3b",     1, 1, 0,  0, 0,  0, 3,  1,  0, 0,  0, 0,   0, 1, 32'h8,      1);
    step("rst_mid",   0, 1, 0,  0, 0,  0, 3,  1,  1, 3,  0, 0,   0, 1, 32'h8,      1);
    step("post_rst",  1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0,   0, 0, 32'h0,      0);
    step("uf_mix",    1, 1, 0,  0, 0,  0, 12, 1,  1, 12, 1, 12,  0, 1, 32'h0,      0);
    step("uf_chk",    1, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0,   0, 0, 32'h0,      1);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
